// File: rtl/ccd_line_scheduler.sv
// ccd_line_scheduler: launches CCD lines in free-run or external-trigger mode and supervises the driver handshake
//   sys_clk, sys_rst_n           : clock, synchronous active-low reset
//   start, stop                  : run control pulses
//   trig_mode, ext_trig          : line source select, asynchronous trigger input
//   line_period, f1_div_cfg,
//   line_total                   : run configuration, sampled on an accepted start
//   drv_busy                     : driver load/transfer activity
//   line_start, f1_cnt, run,
//   line_idx                     : line launch pulse, latched divider, run flag, lines issued
//   done, overrun, cfg_err,
//   drv_err                      : one-cycle event pulses
module ccd_line_scheduler #(
  parameter int MIN_PERIOD  = 1200,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        trig_mode,
  input  logic        ext_trig,
  input  logic [23:0] line_period,
  input  logic [7:0]  f1_div_cfg,
  input  logic [15:0] line_total,
  input  logic        drv_busy,
  output logic        line_start,
  output logic [7:0]  f1_cnt,
  output logic        run,
  output logic [15:0] line_idx,
  output logic        done,
  output logic        overrun,
  output logic        cfg_err,
  output logic        drv_err
);
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, READOUT} state_t;
  localparam int TW = $clog2(ACK_TIMEOUT + 1) + 1;
  state_t        state_q;
  logic [2:0]    sync_q;
  logic [23:0]   per_q, pcnt_q;
  logic [15:0]   total_q, idx_q;
  logic [7:0]    f1_q;
  logic [TW-1:0] tcnt_q;
  logic          tmode_q, first_q, ack_q, stop_pend_q;
  logic          ls_q, done_q, ovr_q, cfg_err_q, drv_err_q;
  logic          trig_edge, expiry, hit, go, bad_cfg, last_line, ovr_d;
  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] holds the previous value for edge detection
  assign trig_edge = sync_q[1] & ~sync_q[2];
  assign expiry    = pcnt_q == per_q - 24'd1;
  // the cycle in which the saturating counter reaches its limit; used to flag overrun once per line
  assign hit       = !expiry && (pcnt_q + 24'd1 == per_q - 24'd1);
  assign go        = tmode_q ? trig_edge : (first_q | expiry);
  assign bad_cfg   = f1_div_cfg < 8'd2 || (!trig_mode && line_period < 24'(MIN_PERIOD));
  assign last_line = (total_q != 16'd0 && idx_q == total_q) || stop_pend_q || stop;
  assign ovr_d     = tmode_q ? trig_edge && (state_q == ISSUE || state_q == READOUT)
                             : hit && state_q == READOUT;
  assign line_start = ls_q;
  assign f1_cnt     = f1_q;
  assign run        = state_q != IDLE;
  assign line_idx   = idx_q;
  assign done       = done_q;
  assign overrun    = ovr_q;
  assign cfg_err    = cfg_err_q;
  assign drv_err    = drv_err_q;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 3'd0;
      per_q       <= 24'd0;
      pcnt_q      <= 24'd0;
      total_q     <= 16'd0;
      idx_q       <= 16'd0;
      f1_q        <= 8'd2;
      tcnt_q      <= '0;
      tmode_q     <= 1'b0;
      first_q     <= 1'b0;
      ack_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      ls_q        <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      drv_err_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], ext_trig};
      ls_q      <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= ovr_d;
      cfg_err_q <= 1'b0;
      drv_err_q <= 1'b0;
      if (state_q != IDLE && !expiry) pcnt_q <= pcnt_q + 24'd1;
      if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          if (bad_cfg) cfg_err_q <= 1'b1;
          else begin
            tmode_q     <= trig_mode;
            per_q       <= line_period;
            total_q     <= line_total;
            f1_q        <= f1_div_cfg;
            idx_q       <= 16'd0;
            pcnt_q      <= 24'd0;
            first_q     <= 1'b1;
            stop_pend_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: if (stop) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end else if (go) begin
          ls_q    <= 1'b1;
          idx_q   <= idx_q + 16'd1;
          pcnt_q  <= 24'd0;
          tcnt_q  <= '0;
          first_q <= 1'b0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          ack_q       <= 1'b0;
          stop_pend_q <= stop_pend_q | stop;
          state_q     <= READOUT;
        end
        default: begin
          stop_pend_q <= stop_pend_q | stop;
          if (!ack_q) begin
            if (drv_busy) ack_q <= 1'b1;
            else if (tcnt_q >= TW'(ACK_TIMEOUT - 1)) begin
              drv_err_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (!drv_busy) begin
            done_q  <= last_line;
            state_q <= last_line ? IDLE : WAIT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ccd_line_scheduler.sv
// tb_ccd_line_scheduler: directed checks of line timing, overrun, stop, error and reset behaviour
module tb_ccd_line_scheduler;
  logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, trig_mode = 1'b0, ext_trig = 1'b0, drv_busy = 1'b0;
  logic [23:0] line_period = 24'd0;
  logic [7:0]  f1_div_cfg = 8'd0;
  logic [15:0] line_total = 16'd0;
  logic        line_start, run, done, overrun, cfg_err, drv_err;
  logic [7:0]  f1_cnt;
  logic [15:0] line_idx;
  int n_vec = 0, n_err = 0, now = 0, ls_cnt = 0, ovr_cnt = 0;
  int t0, t1, t2, ta, base_ls, base_ovr;
  ccd_line_scheduler dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
    .trig_mode(trig_mode), .ext_trig(ext_trig), .line_period(line_period),
    .f1_div_cfg(f1_div_cfg), .line_total(line_total), .drv_busy(drv_busy),
    .line_start(line_start), .f1_cnt(f1_cnt), .run(run), .line_idx(line_idx),
    .done(done), .overrun(overrun), .cfg_err(cfg_err), .drv_err(drv_err)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) now = now + 1;
  always @(negedge sys_clk) begin
    if (line_start) ls_cnt = ls_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start_run(input logic tm, input logic [23:0] per, input logic [7:0] f1, input logic [15:0] tot);
    trig_mode = tm;
    line_period = per;
    f1_div_cfg = f1;
    line_total = tot;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic drive_busy(input int len);
    drv_busy = 1'b1;
    repeat (len) tick();
    drv_busy = 1'b0;
  endtask
  task automatic wait_ls(input int max);
    int k = 0;
    while (!line_start && k < max) begin
      tick();
      k++;
    end
    chk("line_start_wait", line_start, 1);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_run", run, 0);
    chk("rst_f1", f1_cnt, 2);
    chk("rst_idx", line_idx, 0);
    chk("rst_ls", line_start, 0);
    chk("rst_done", done, 0);
    sys_rst_n = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_done", done, 0);
    chk("idle_stop_run", run, 0);
    start_run(1'b0, 24'd2000, 8'd1, 16'd3);
    chk("cfg_f1_err", cfg_err, 1);
    chk("cfg_f1_run", run, 0);
    chk("cfg_f1_cnt", f1_cnt, 2);
    tick();
    chk("cfg_err_pulse", cfg_err, 0);
    start_run(1'b0, 24'd100, 8'd5, 16'd3);
    chk("cfg_per_err", cfg_err, 1);
    chk("cfg_per_run", run, 0);
    chk("cfg_per_cnt", f1_cnt, 2);
    tick();
    base_ovr = ovr_cnt;
    start_run(1'b0, 24'd2000, 8'd4, 16'd3);
    chk("fr_run", run, 1);
    chk("fr_f1", f1_cnt, 4);
    chk("fr_idx0", line_idx, 0);
    tick();
    chk("fr_ls0", line_start, 1);
    chk("fr_idx1", line_idx, 1);
    t0 = now;
    tick();
    chk("fr_ls_width", line_start, 0);
    drive_busy(799);
    tick();
    chk("fr_nodone1", done, 0);
    wait_ls(2100);
    t1 = now;
    chk("fr_t1", t1 - t0, 2000);
    drive_busy(800);
    tick();
    wait_ls(2100);
    t2 = now;
    chk("fr_t2", t2 - t0, 4000);
    chk("fr_idx3", line_idx, 3);
    drive_busy(800);
    tick();
    chk("fr_done", done, 1);
    chk("fr_run_end", run, 0);
    chk("fr_idx_end", line_idx, 3);
    chk("fr_no_ovr", ovr_cnt - base_ovr, 0);
    tick();
    chk("fr_done_width", done, 0);
    base_ovr = ovr_cnt;
    start_run(1'b0, 24'd1200, 8'd3, 16'd2);
    tick();
    chk("ov_ls0", line_start, 1);
    drive_busy(1500);
    t1 = now;
    chk("ov_ovr1", ovr_cnt - base_ovr, 1);
    tick();
    wait_ls(3);
    chk("ov_follow", now - t1, 2);
    drive_busy(1500);
    tick();
    chk("ov_done", done, 1);
    chk("ov_ovr2", ovr_cnt - base_ovr, 2);
    chk("ov_idx", line_idx, 2);
    tick();
    base_ls = ls_cnt;
    base_ovr = ovr_cnt;
    start_run(1'b1, 24'd0, 8'd3, 16'd0);
    repeat (5) tick();
    chk("tg_quiet", ls_cnt - base_ls, 0);
    #2 ext_trig = 1'b1;
    ta = now;
    repeat (2) tick();
    chk("tg_not_yet", line_start, 0);
    tick();
    chk("tg_ls", line_start, 1);
    chk("tg_latency", now - ta, 3);
    drv_busy = 1'b1;
    ext_trig = 1'b0;
    repeat (10) tick();
    #3 ext_trig = 1'b1;
    repeat (10) tick();
    drv_busy = 1'b0;
    repeat (6) tick();
    chk("tg_ovr", ovr_cnt - base_ovr, 1);
    chk("tg_one_line", ls_cnt - base_ls, 1);
    chk("tg_idx", line_idx, 1);
    chk("tg_run", run, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("tg_stop_done", done, 1);
    chk("tg_stop_run", run, 0);
    ext_trig = 1'b0;
    tick();
    start_run(1'b0, 24'd1200, 8'd6, 16'd0);
    tick();
    chk("sr_ls", line_start, 1);
    drv_busy = 1'b1;
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sr_still_run", run, 1);
    chk("sr_no_done", done, 0);
    repeat (10) tick();
    drv_busy = 1'b0;
    tick();
    chk("sr_done", done, 1);
    chk("sr_idle", run, 0);
    chk("sr_idx", line_idx, 1);
    tick();
    base_ls = ls_cnt;
    start_run(1'b0, 24'd1200, 8'd6, 16'd0);
    tick();
    t0 = now;
    drive_busy(100);
    while (now < t0 + 1199) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sw_no_ls", line_start, 0);
    chk("sw_done", done, 1);
    chk("sw_idle", run, 0);
    chk("sw_lines", ls_cnt - base_ls, 1);
    tick();
    start_run(1'b0, 24'd1200, 8'd7, 16'd0);
    tick();
    t0 = now;
    while (now < t0 + 63) tick();
    chk("de_early", drv_err, 0);
    tick();
    chk("de_err", drv_err, 1);
    chk("de_idle", run, 0);
    chk("de_no_done", done, 0);
    tick();
    start_run(1'b0, 24'd1500, 8'd9, 16'd0);
    tick();
    drv_busy = 1'b1;
    repeat (20) tick();
    chk("rs_pre_f1", f1_cnt, 9);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("rs_run", run, 0);
    chk("rs_idx", line_idx, 0);
    chk("rs_f1", f1_cnt, 2);
    chk("rs_done", done, 0);
    chk("rs_ls", line_start, 0);
    chk("rs_drv_err", drv_err, 0);
    repeat (5) tick();
    drv_busy = 1'b0;
    tick();
    chk("rs_no_done", done, 0);
    chk("rs_stay_idle", run, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ccd_line_scheduler.md
CCD_LINE_SCHEDULER -- requirements
Module: ccd_line_scheduler

Interface
REQ-001 Parameter MIN_PERIOD, default 1200: smallest accepted line_period, in sys_clk cycles.
REQ-002 Parameter ACK_TIMEOUT, default 64: maximum number of cycles from line_start until drv_busy must rise.
REQ-003 Port sys_clk, input, 1: single clock, rising edge; all logic is in this domain.
REQ-004 Port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port start, input, 1: one-cycle pulse that begins a run; ignored unless in IDLE.
REQ-006 Port stop, input, 1: one-cycle pulse that requests a graceful end of the run.
REQ-007 Port trig_mode, input, 1: 0 = free-run, 1 = external trigger; sampled at start.
REQ-008 Port ext_trig, input, 1: asynchronous line trigger.
REQ-009 Port line_period, input, 24: free-run line period in cycles; sampled at start.
REQ-010 Port f1_div_cfg, input, 8: requested f1 divider; sampled at start.
REQ-011 Port line_total, input, 16: number of lines per run; 0 = run continuously; sampled at start.
REQ-012 Port drv_busy, input, 1: high while the CCD driver is in its load/transfer phases.
REQ-013 Port line_start, output, 1: one-cycle pulse that launches one CCD line.
REQ-014 Port f1_cnt, output, 8: latched divider value fed to the driver.
REQ-015 Port run, output, 1: high in every state except IDLE.
REQ-016 Port line_idx, output, 16: number of lines issued in the current run.
REQ-017 Port done, output, 1: one-cycle pulse when a run ends normally.
REQ-018 Port overrun, output, 1: one-cycle pulse when a trigger or period expiry hits a busy driver.
REQ-019 Port cfg_err, output, 1: one-cycle pulse when start is rejected.
REQ-020 Port drv_err, output, 1: one-cycle pulse when the driver acknowledge times out.

Function
REQ-021 The block SHALL implement four states: IDLE, WAIT, ISSUE and READOUT.
REQ-022 ext_trig SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, so a trigger is recognised 3 cycles after the asynchronous edge.
REQ-023 On start in IDLE, the block SHALL reject the run if f1_div_cfg<2 or (trig_mode=0 and line_period<MIN_PERIOD): it pulses cfg_err in the next cycle and stays in IDLE.
REQ-024 On an accepted start, the block SHALL latch trig_mode, line_period, line_total and f1_cnt<=f1_div_cfg, clear line_idx, and go to WAIT.
REQ-025 f1_cnt SHALL change only on an accepted start; it is stable for the whole run.
REQ-026 WAIT, free-run: the block SHALL go to ISSUE on the first cycle after the WAIT entry from start; thereafter it issues when the period counter reaches line_period-1.
REQ-027 WAIT, trigger mode: the block SHALL go to ISSUE on a synchronized trigger edge.
REQ-028 ISSUE SHALL last exactly 1 cycle with line_start=1, SHALL increment line_idx (16-bit, wrapping), SHALL clear the period counter, and SHALL then go to READOUT.
REQ-029 The period counter SHALL be 24-bit, SHALL count every cycle while run=1, and SHALL saturate at line_period-1.
REQ-030 READOUT SHALL first wait for drv_busy=1; if drv_busy has not risen within ACK_TIMEOUT cycles of line_start, the block pulses drv_err and goes to IDLE without pulsing done.
REQ-031 After drv_busy rises, the block SHALL wait for drv_busy=0 and then evaluate the end conditions.
REQ-032 When drv_busy falls, the block SHALL go to IDLE and pulse done if line_total!=0 and line_idx==line_total, or if a stop is pending; otherwise it returns to WAIT.
REQ-033 Free-run period expiry while in READOUT SHALL pulse overrun once; the next line_start then occurs in the cycle after WAIT is re-entered.
REQ-034 A trigger edge in READOUT or ISSUE SHALL pulse overrun and SHALL be discarded, not queued.
REQ-035 stop in WAIT SHALL go to IDLE with done on the next cycle; stop in ISSUE or READOUT SHALL set stop_pend, which takes effect per REQ-032.
REQ-036 stop and start in IDLE SHALL be ignored (start is handled only per REQ-023/REQ-024).
REQ-037 If stop coincides with a trigger edge or a period expiry in WAIT, stop SHALL win and no line_start is issued.
REQ-038 line_start, done, overrun, cfg_err and drv_err SHALL each be registered outputs, high for exactly one cycle per event.

Reset
REQ-039 With sys_rst_n=0 at a clock edge, the block SHALL enter IDLE and set line_start, run, done, overrun, cfg_err, drv_err, line_idx, stop_pend, the period counter and the synchronizer flops to 0, and f1_cnt=8'd2.
REQ-040 Reset asserted mid-run SHALL abort immediately without a done pulse; drv_busy is then ignored until the next start.

Verification
REQ-041 Free-run, line_period=2000, line_total=3, driver busy for 800 cycles -> line_start pulses at t0, t0+2000 and t0+4000, line_idx ends at 3, done pulses after the third drv_busy fall, run drops.
REQ-042 Free-run, line_period=1200, driver busy for 1500 cycles -> overrun pulses once per line and line_start follows each drv_busy fall within 2 cycles.
REQ-043 Trigger mode: async ext_trig edge -> line_start 3-4 cycles later; a second edge during drv_busy produces overrun and no extra line.
REQ-044 start with f1_div_cfg=1, or with line_period=100 in free-run -> cfg_err pulse, run stays 0, f1_cnt is unchanged.
REQ-045 Stop cases: stop mid-READOUT -> the current line completes, then done and IDLE; stop coinciding with a period expiry in WAIT -> IDLE with no line_start.
REQ-046 Error and reset cases: drv_busy held low after line_start -> drv_err at line_start+ACK_TIMEOUT and IDLE; sys_rst_n pulsed mid-run -> all outputs take their reset values one edge later.
